// File: rtl/rdout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rdout_pkg
//  Description : Shared constants, header layout and state encoding for the
//                readout W_out/est snapshot reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package rdout_pkg;

   localparam int          N_W       = 8;
   localparam int          W_BITS    = 32;
   localparam int          ADDR_BITS = 6;
   localparam int          CNT_BITS  = 16;
   localparam int          FRAME_LEN = N_W + 2;
   localparam int          IDX_BITS  = 4;
   localparam int          SEL_BITS  = 3;
   localparam logic [7:0]  HDR_MAGIC = 8'hA5;

   // Header field positions
   localparam int HDR_MAGIC_LSB = 24;
   localparam int HDR_TCE_BIT   = 23;
   localparam int HDR_RSVD_BIT  = 22;
   localparam int HDR_ADDR_LSB  = 16;
   localparam int HDR_CNT_LSB   = 0;

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_LEN - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Assemble the frame header word from captured fields and frame count
   function automatic logic [31:0] make_header(
      input logic                 tce,
      input logic [ADDR_BITS-1:0] addr,
      input logic [CNT_BITS-1:0]  cnt
   );
      logic [31:0] h;
      h                                 = '0;
      h[HDR_MAGIC_LSB +: 8]             = HDR_MAGIC;
      h[HDR_TCE_BIT]                    = tce;
      h[HDR_RSVD_BIT]                   = 1'b0;
      h[HDR_ADDR_LSB +: ADDR_BITS]      = addr;
      h[HDR_CNT_LSB +: CNT_BITS]        = cnt;
      return h;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rdout_wout_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : rdout_wout_shadow
//  Description : Capture-enabled shadow bank for W_out/est/addr/train_ce and
//                the word multiplexer that builds each frame word.
//  Revision    : 1.0 - initial release
// ============================================================================
module rdout_wout_shadow
   import rdout_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_N,
   input  logic                    i_cap,
   input  logic                    i_train_ce,
   input  logic [N_W*W_BITS-1:0]   i_w_out,
   input  logic [W_BITS-1:0]       i_est,
   input  logic [ADDR_BITS-1:0]    i_addr,
   input  logic [IDX_BITS-1:0]     i_word_idx,
   input  logic [CNT_BITS-1:0]     i_frame_cnt,
   output logic [31:0]             o_word
);

   logic [N_W*W_BITS-1:0] r_w;
   logic [W_BITS-1:0]     r_est;
   logic [ADDR_BITS-1:0]  r_addr;
   logic                  r_tce;

   logic [W_BITS-1:0]     w_wt [N_W];
   logic [SEL_BITS-1:0]   w_sel;

   // Latch a coherent copy of all live inputs on the capture strobe
   always_ff @(posedge clk) begin
      if (!rst_N) begin
         r_w    <= '0;
         r_est  <= '0;
         r_addr <= '0;
         r_tce  <= 1'b0;
      end else if (i_cap) begin
         r_w    <= i_w_out;
         r_est  <= i_est;
         r_addr <= i_addr;
         r_tce  <= i_train_ce;
      end
   end

   for (genvar gi = 0; gi < N_W; gi++) begin : g_split
      assign w_wt[gi] = r_w[gi*W_BITS +: W_BITS];
   end

   // Words 1..N_W map to weights 0..N_W-1
   assign w_sel = SEL_BITS'(i_word_idx - IDX_BITS'(1));

   // Select header, weight or estimate according to the word index
   always_comb begin
      o_word = '0;
      if (i_word_idx == '0) begin
         o_word = make_header(r_tce, r_addr, i_frame_cnt);
      end else if (i_word_idx == LAST_IDX) begin
         o_word = r_est;
      end else begin
         o_word = w_wt[w_sel];
      end
   end

endmodule
`default_nettype wire

// File: rtl/rdout_wout_readback.sv
`default_nettype none
// ============================================================================
//  Module      : rdout_wout_readback
//  Description : Snapshots readout W_out/est/addr on request and streams them
//                as a 10-word valid/ready frame (header, 8 weights, est).
//                Optional build macro RDOUT_AUTO_SNAP_EN adds an automatic
//                snapshot on the falling edge of train_ce.
//  Revision    : 1.0 - initial release
// ============================================================================
module rdout_wout_readback
   import rdout_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_N,
   input  logic                    train_ce,
   input  logic [N_W*W_BITS-1:0]   W_out,
   input  logic [W_BITS-1:0]       est,
   input  logic [ADDR_BITS-1:0]    addr,
   input  logic                    snap_req,
   output logic                    busy,
   output logic                    snap_done,
   output logic                    snap_overrun,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [31:0]             m_data,
   output logic                    m_last
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_BITS-1:0]   r_idx;
   logic [IDX_BITS-1:0]   w_idx_nxt;
   logic [CNT_BITS-1:0]   r_frame_cnt;
   logic [CNT_BITS-1:0]   w_frame_cnt_nxt;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  r_ovr;
   logic                  w_ovr_nxt;
   logic                  w_cap;
   logic                  w_req;
   logic [31:0]           w_word;

`ifdef RDOUT_AUTO_SNAP_EN
   logic r_tce_d;

   // Remember previous train_ce to spot the end of training
   always_ff @(posedge clk) begin
      if (!rst_N) begin
         r_tce_d <= 1'b0;
      end else begin
         r_tce_d <= train_ce;
      end
   end

   assign w_req = snap_req | (r_tce_d & ~train_ce);
`else
   assign w_req = snap_req;
`endif

   // State, word index, frame counter and status pulse registers
   always_ff @(posedge clk) begin
      if (!rst_N) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_frame_cnt <= '0;
         r_done      <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_done      <= w_done_nxt;
         r_ovr       <= w_ovr_nxt;
      end
   end

   // Next-state logic: capture in IDLE, advance one word per handshake in SEND
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_frame_cnt_nxt = r_frame_cnt;
      w_done_nxt      = 1'b0;
      w_ovr_nxt       = 1'b0;
      w_cap           = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_cap       = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            // Requests during a frame are dropped, not queued
            w_ovr_nxt = w_req;
            if (m_ready) begin
               if (r_idx == LAST_IDX) begin
                  w_state_nxt     = IDLE;
                  w_done_nxt      = 1'b1;
                  w_frame_cnt_nxt = r_frame_cnt + CNT_BITS'(1);
               end else begin
                  w_idx_nxt = r_idx + IDX_BITS'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   rdout_wout_shadow u_shadow (
      .clk         (clk),
      .rst_N       (rst_N),
      .i_cap       (w_cap),
      .i_train_ce  (train_ce),
      .i_w_out     (W_out),
      .i_est       (est),
      .i_addr      (addr),
      .i_word_idx  (r_idx),
      .i_frame_cnt (r_frame_cnt),
      .o_word      (w_word)
   );

   assign busy         = (r_state == SEND);
   assign m_valid      = (r_state == SEND);
   // Data is forced to zero outside a frame so idle/reset outputs read 0
   assign m_data       = m_valid ? w_word : 32'h0;
   assign m_last       = m_valid && (r_idx == LAST_IDX);
   assign snap_done    = r_done;
   assign snap_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_rdout_wout_readback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rdout_wout_readback
//  Description : Directed self-checking bench for rdout_wout_readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rdout_wout_readback;

   logic          clk;
   logic          rst_N;
   logic          train_ce;
   logic [255:0]  W_out;
   logic [31:0]   est;
   logic [5:0]    addr;
   logic          snap_req;
   logic          busy;
   logic          snap_done;
   logic          snap_overrun;
   logic          m_valid;
   logic          m_ready;
   logic [31:0]   m_data;
   logic          m_last;

   int n_assert;
   int n_fail;

   rdout_wout_readback dut (
      .clk          (clk),
      .rst_N        (rst_N),
      .train_ce     (train_ce),
      .W_out        (W_out),
      .est          (est),
      .addr         (addr),
      .snap_req     (snap_req),
      .busy         (busy),
      .snap_done    (snap_done),
      .snap_overrun (snap_overrun),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference frame word: header, weights base+0..7, then est
   function automatic logic [31:0] exp_word(input int k, input logic tce, input logic [5:0] a,
                                            input logic [15:0] cnt, input logic [31:0] wbase,
                                            input logic [31:0] e);
      if (k == 0) return {8'hA5, tce, 1'b0, a, cnt};
      if (k == 9) return e;
      return wbase + 32'(k - 1);
   endfunction

   task automatic set_inputs(input logic [31:0] wbase, input logic [31:0] e, input logic [5:0] a);
      for (int i = 0; i < 8; i++) W_out[i*32 +: 32] = wbase + 32'(i);
      est  = e;
      addr = a;
   endtask

   // Consume a whole frame with m_ready=1, starting while the header is shown
   task automatic send_frame(input logic tce, input logic [5:0] a, input logic [15:0] cnt,
                             input logic [31:0] wbase, input logic [31:0] e, input bit scramble);
      m_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check("frm_valid", 32'(m_valid), 32'd1);
         check("frm_data",  m_data, exp_word(k, tce, a, cnt, wbase, e));
         check("frm_last",  32'(m_last), (k == 9) ? 32'd1 : 32'd0);
         check("frm_done_low", 32'(snap_done), 32'd0);
         tick();
         if (scramble) begin
            for (int i = 0; i < 8; i++) W_out[i*32 +: 32] = $urandom;
            est  = $urandom;
            addr = 6'($urandom);
         end
      end
      check("end_valid", 32'(m_valid), 32'd0);
      check("end_busy",  32'(busy), 32'd0);
      check("end_done",  32'(snap_done), 32'd1);
   endtask

   initial begin
      int k;
      int cyc;
      n_assert = 0;
      n_fail   = 0;
      rst_N    = 1'b0;
      train_ce = 1'b0;
      W_out    = '0;
      est      = '0;
      addr     = '0;
      snap_req = 1'b0;
      m_ready  = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_valid",   32'(m_valid), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_data",    m_data, 32'd0);
      check("rst_last",    32'(m_last), 32'd0);
      check("rst_done",    32'(snap_done), 32'd0);
      check("rst_overrun", 32'(snap_overrun), 32'd0);
      rst_N    = 1'b1;
      train_ce = 1'b1;
      tick();
      check("idle_no_frame", 32'(m_valid), 32'd0);

      // Basic frame
      set_inputs(32'h1000_0000, 32'hFFFF_FF80, 6'd37);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("basic_busy", 32'(busy), 32'd1);
      check("basic_hdr",  m_data, 32'hA5A5_0000);
      send_frame(1'b1, 6'd37, 16'd0, 32'h1000_0000, 32'hFFFF_FF80, 1'b0);
      tick();
      check("done_one_cycle", 32'(snap_done), 32'd0);

      // Coherency: live inputs scrambled every cycle of the frame
      set_inputs(32'h2000_0000, 32'h1234_5678, 6'd37);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("second_hdr", m_data, 32'hA5A5_0001);
      send_frame(1'b1, 6'd37, 16'd1, 32'h2000_0000, 32'h1234_5678, 1'b1);
      tick();

      // Backpressure: m_ready pattern 1,0,0,1,0,0,...
      set_inputs(32'h3000_0000, 32'hDEAD_BEEF, 6'd0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < 10 && cyc < 100) begin
         m_ready = ((cyc % 3) == 0);
         check("bp_valid", 32'(m_valid), 32'd1);
         check("bp_data",  m_data, exp_word(k, 1'b1, 6'd0, 16'd2, 32'h3000_0000, 32'hDEAD_BEEF));
         check("bp_last",  32'(m_last), (k == 9) ? 32'd1 : 32'd0);
         if (m_ready) k++;
         tick();
         cyc++;
      end
      check("bp_words", 32'(k), 32'd10);
      check("bp_end_valid", 32'(m_valid), 32'd0);
      check("bp_end_done",  32'(snap_done), 32'd1);
      m_ready = 1'b1;
      tick();

      // Overrun: requests at word 4 and at the final handshake
      set_inputs(32'h4000_0000, 32'h0BAD_F00D, 6'd21);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      for (int j = 0; j < 10; j++) begin
         check("ovr_data", m_data, exp_word(j, 1'b1, 6'd21, 16'd3, 32'h4000_0000, 32'h0BAD_F00D));
         snap_req = (j == 4 || j == 9);
         tick();
         snap_req = 1'b0;
         check("ovr_pulse", 32'(snap_overrun), (j == 4 || j == 9) ? 32'd1 : 32'd0);
      end
      check("ovr_end_done",  32'(snap_done), 32'd1);
      check("ovr_end_valid", 32'(m_valid), 32'd0);
      tick();
      check("ovr_not_queued", 32'(m_valid), 32'd0);
      check("ovr_pulse_clr",  32'(snap_overrun), 32'd0);

      // Reset mid-frame at word 6
      set_inputs(32'h5000_0000, 32'h0000_0055, 6'd1);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("rstmid_hdr", m_data, 32'hA581_0004);
      for (int j = 0; j < 6; j++) tick();
      check("rstmid_w6", m_data, 32'h5000_0005);
      rst_N = 1'b0;
      tick();
      rst_N = 1'b1;
      check("rstmid_valid", 32'(m_valid), 32'd0);
      check("rstmid_busy",  32'(busy), 32'd0);
      check("rstmid_done",  32'(snap_done), 32'd0);
      tick();
      check("rstmid_done2", 32'(snap_done), 32'd0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("rstmid_cnt0", {16'h0, m_data[15:0]}, 32'h0000_0000);
      send_frame(1'b1, 6'd1, 16'd0, 32'h5000_0000, 32'h0000_0055, 1'b0);

      // New request in the snap_done cycle is accepted
      set_inputs(32'h6000_0000, 32'h6666_6666, 6'd2);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("b2b_valid", 32'(m_valid), 32'd1);
      send_frame(1'b1, 6'd2, 16'd1, 32'h6000_0000, 32'h6666_6666, 1'b0);
      tick();

      // train_ce falling edge
      rst_N    = 1'b0;
      train_ce = 1'b1;
      tick();
      rst_N = 1'b1;
      tick();
      tick();
      set_inputs(32'h7000_0000, 32'h7777_7777, 6'd63);
      train_ce = 1'b0;
      tick();
`ifdef RDOUT_AUTO_SNAP_EN
      check("auto_valid", 32'(m_valid), 32'd1);
      check("auto_hdr",   m_data, 32'hA53F_0000);
      send_frame(1'b0, 6'd63, 16'd0, 32'h7000_0000, 32'h7777_7777, 1'b0);
`else
      check("noauto_valid", 32'(m_valid), 32'd0);
      tick();
      check("noauto_busy",  32'(busy), 32'd0);
`endif
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
